mux_4to1_rr_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-to-1 multiplexer datapath among four requesters. It grants at most one requester at a time, drives the mux select lines `s1`/`s0` from the grant, and registers the selected data word with a valid flag. A hold limit bounds how long one requester may keep the datapath. The block sits directly in front of `mux_4to1_hr` (or an equivalent `WIDTH`-wide mux) and is the only driver of its select inputs.

---
 rtl/mux_4to1_rr_arb_pkg.sv | 22 ++
 rtl/mux_4to1_rr_arb_if.sv | 25 ++
 rtl/mux_4to1_rr_arb_rr_pick4.sv | 28 ++
 rtl/mux_4to1_rr_arb.sv | 126 ++++++++++++
 tb/tb_mux_4to1_rr_arb.sv | 131 +++++++++++++
 5 files changed

// File: rtl/mux_4to1_rr_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Includes the FSM encoding, requester sizing and small helper functions.
package mux_arb_pkg;

    localparam int IDX_W = 2;
    localparam int NREQ  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // hold counter never narrower than one bit, even for MAX_HOLD=1
    function automatic int hold_w(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_4to1_rr_arb_if.sv
// Request/data/grant bundle between the four requesters and the arbiter.
interface mux_4to1_rr_arb_if #(
    parameter int WIDTH = 1
);
    logic [3:0]       req;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] x3;
    logic [3:0]       gnt;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] f;
    logic             f_valid;

    modport master (
        output req, x0, x1, x2, x3,
        input  gnt, s1, s0, f, f_valid
    );

    modport slave (
        input  req, x0, x1, x2, x3,
        output gnt, s1, s0, f, f_valid
    );
endinterface

// File: rtl/mux_4to1_rr_arb_rr_pick4.sv
// Combinational round-robin picker: first set request at or above ptr, mod 4.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic [IDX_W-1:0]  off_s;

    // rotate so ptr lands on bit 0, then priority-encode the lowest set bit
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[NREQ-1:0];
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        idx = ptr + off_s;
        any = |req;
    end
endmodule

// File: rtl/mux_4to1_rr_arb.sv
// Round-robin arbiter driving a shared 4-to-1 mux select, with hold limit
// and a registered data/valid output stage one cycle behind the grant.
module mux_4to1_rr_arb
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_4to1_rr_arb_if.slave     bus
);
    localparam int                HOLD_W   = hold_w(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [31:0]       HOLD_LIM = 32'(MAX_HOLD - 1);

    state_t            state_r, state_s;
    logic [NREQ-1:0]   gnt_r, gnt_s;
    logic [IDX_W-1:0]  sel_r, sel_s;
    logic [IDX_W-1:0]  ptr_r, ptr_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic [WIDTH-1:0]  f_r, data_s;
    logic              f_valid_r;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic              keep_s;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // arbitration state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'b00;
            ptr_r   <= 2'b00;
            hold_r  <= '0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            ptr_r   <= ptr_s;
            hold_r  <= hold_s;
        end
    end

    // next grant: keep owner until it drops or its hold budget runs out
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        ptr_s   = ptr_r;
        hold_s  = hold_r;
        keep_s  = bus.req[sel_r] && (32'(hold_r) < HOLD_LIM);
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_s = ST_BUSY;
                    gnt_s   = idx_to_onehot(pick_idx_s);
                    sel_s   = pick_idx_s;
                    ptr_s   = pick_idx_s + 2'd1;
                    hold_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (keep_s) begin
                    hold_s = hold_r + HOLD_ONE;
                end else if (pick_any_s) begin
                    // ptr already sits at owner+1, so a lone owner wraps back to itself
                    gnt_s  = idx_to_onehot(pick_idx_s);
                    sel_s  = pick_idx_s;
                    ptr_s  = pick_idx_s + 2'd1;
                    hold_s = '0;
                end else begin
                    state_s = ST_IDLE;
                    gnt_s   = 4'b0000;
                    hold_s  = '0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 4'b0000;
                hold_s  = '0;
            end
        endcase
    end

    // shared mux datapath selected by the registered grant index
    always_comb begin
        case (sel_r)
            2'd0:    data_s = bus.x0;
            2'd1:    data_s = bus.x1;
            2'd2:    data_s = bus.x2;
            2'd3:    data_s = bus.x3;
            default: data_s = bus.x0;
        endcase
    end

    // output stage; f holds across idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            f_r       <= '0;
            f_valid_r <= 1'b0;
        end else begin
            f_valid_r <= |gnt_r;
            if (|gnt_r) begin
                f_r <= data_s;
            end else begin
                f_r <= f_r;
            end
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.s1      = sel_r[1];
    assign bus.s0      = sel_r[0];
    assign bus.f       = f_r;
    assign bus.f_valid = f_valid_r;
endmodule

// File: tb/tb_mux_4to1_rr_arb.sv
// Directed vector bench: MAX_HOLD=4 instance driven from a vector table,
// MAX_HOLD=8 instance exercised by a sole-requester sequence.
module tb_mux_4to1_rr_arb;
    localparam int W = 4;
    localparam logic [W-1:0] XA = 4'hA, XB = 4'h5, XC = 4'h3, XD = 4'hC;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [3:0] f;
        logic       fv;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t vecs[33];

    mux_4to1_rr_arb_if #(.WIDTH(W)) bus_a ();
    mux_4to1_rr_arb_if #(.WIDTH(W)) bus_b ();

    mux_4to1_rr_arb #(.WIDTH(W), .MAX_HOLD(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus_a));
    mux_4to1_rr_arb #(.WIDTH(W), .MAX_HOLD(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] g,
                                input logic [1:0] s, input logic [3:0] ff, input logic v);
        vec_t t;
        t.rst = r; t.req = rq; t.gnt = g; t.sel = s; t.f = ff; t.fv = v;
        return t;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, row, got, exp);
        end
    endtask

    initial begin
        // reset, single request, idle return
        vecs[0]  = mk(1'b1, 4'b0000, 4'b0000, 2'd0, 4'h0, 1'b0);
        vecs[1]  = mk(1'b1, 4'b0000, 4'b0000, 2'd0, 4'h0, 1'b0);
        vecs[2]  = mk(1'b0, 4'b0100, 4'b0100, 2'd2, 4'h0, 1'b0);
        vecs[3]  = mk(1'b0, 4'b0000, 4'b0000, 2'd2, XC,   1'b1);
        vecs[4]  = mk(1'b0, 4'b0000, 4'b0000, 2'd2, XC,   1'b0);
        // rotation with all four requesting, MAX_HOLD=4
        vecs[5]  = mk(1'b1, 4'b1111, 4'b0000, 2'd0, 4'h0, 1'b0);
        vecs[6]  = mk(1'b0, 4'b1111, 4'b0001, 2'd0, 4'h0, 1'b0);
        vecs[7]  = mk(1'b0, 4'b1111, 4'b0001, 2'd0, XA,   1'b1);
        vecs[8]  = mk(1'b0, 4'b1111, 4'b0001, 2'd0, XA,   1'b1);
        vecs[9]  = mk(1'b0, 4'b1111, 4'b0001, 2'd0, XA,   1'b1);
        vecs[10] = mk(1'b0, 4'b1111, 4'b0010, 2'd1, XA,   1'b1);
        vecs[11] = mk(1'b0, 4'b1111, 4'b0010, 2'd1, XB,   1'b1);
        vecs[12] = mk(1'b0, 4'b1111, 4'b0010, 2'd1, XB,   1'b1);
        vecs[13] = mk(1'b0, 4'b1111, 4'b0010, 2'd1, XB,   1'b1);
        vecs[14] = mk(1'b0, 4'b1111, 4'b0100, 2'd2, XB,   1'b1);
        vecs[15] = mk(1'b0, 4'b1111, 4'b0100, 2'd2, XC,   1'b1);
        vecs[16] = mk(1'b0, 4'b1111, 4'b0100, 2'd2, XC,   1'b1);
        vecs[17] = mk(1'b0, 4'b1111, 4'b0100, 2'd2, XC,   1'b1);
        vecs[18] = mk(1'b0, 4'b1111, 4'b1000, 2'd3, XC,   1'b1);
        vecs[19] = mk(1'b0, 4'b1111, 4'b1000, 2'd3, XD,   1'b1);
        vecs[20] = mk(1'b0, 4'b1111, 4'b1000, 2'd3, XD,   1'b1);
        vecs[21] = mk(1'b0, 4'b1111, 4'b1000, 2'd3, XD,   1'b1);
        vecs[22] = mk(1'b0, 4'b1111, 4'b0001, 2'd0, XD,   1'b1);
        // owner 0 drops while 1 and 3 request; then owner 1 releases early to 3
        vecs[23] = mk(1'b0, 4'b1010, 4'b0010, 2'd1, XA,   1'b1);
        vecs[24] = mk(1'b0, 4'b1010, 4'b0010, 2'd1, XB,   1'b1);
        vecs[25] = mk(1'b0, 4'b1000, 4'b1000, 2'd3, XB,   1'b1);
        vecs[26] = mk(1'b0, 4'b1000, 4'b1000, 2'd3, XD,   1'b1);
        // reset mid-grant, pointer back to 0
        vecs[27] = mk(1'b1, 4'b1000, 4'b0000, 2'd0, 4'h0, 1'b0);
        vecs[28] = mk(1'b0, 4'b1001, 4'b0001, 2'd0, 4'h0, 1'b0);
        vecs[29] = mk(1'b0, 4'b0000, 4'b0000, 2'd0, XA,   1'b1);
        vecs[30] = mk(1'b0, 4'b0000, 4'b0000, 2'd0, XA,   1'b0);
        // one-cycle pulse still gets a grant
        vecs[31] = mk(1'b0, 4'b0010, 4'b0010, 2'd1, XA,   1'b0);
        vecs[32] = mk(1'b0, 4'b0000, 4'b0000, 2'd1, XB,   1'b1);

        bus_a.req = 4'b0000; bus_b.req = 4'b0000;
        bus_a.x0 = XA; bus_a.x1 = XB; bus_a.x2 = XC; bus_a.x3 = XD;
        bus_b.x0 = XA; bus_b.x1 = XB; bus_b.x2 = XC; bus_b.x3 = XD;

        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            bus_a.req = vecs[i].req;
            @(posedge clk);
            #1;
            check("gnt",     i, 32'(bus_a.gnt), 32'(vecs[i].gnt));
            check("sel",     i, 32'({bus_a.s1, bus_a.s0}), 32'(vecs[i].sel));
            check("f",       i, 32'(bus_a.f), 32'(vecs[i].f));
            check("f_valid", i, 32'(bus_a.f_valid), 32'(vecs[i].fv));
        end

        // sole requester on the MAX_HOLD=8 instance keeps the grant across expiries
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus_b.req = 4'b0001;
            @(posedge clk);
            #1;
            check("sole_gnt", i, 32'(bus_b.gnt), 32'(4'b0001));
            if (i > 0) begin
                check("sole_f_valid", i, 32'(bus_b.f_valid), 32'(1'b1));
                check("sole_f",       i, 32'(bus_b.f), 32'(XA));
            end else begin
                check("sole_first_f_valid", i, 32'(bus_b.f_valid), 32'(1'b0));
            end
        end
        @(negedge clk);
        bus_b.req = 4'b0000;
        @(posedge clk);
        #1;
        check("drop_gnt",     0, 32'(bus_b.gnt), 32'(4'b0000));
        check("drop_f_valid", 0, 32'(bus_b.f_valid), 32'(1'b1));
        @(posedge clk);
        #1;
        check("idle_f_valid", 1, 32'(bus_b.f_valid), 32'(1'b0));
        check("idle_f",       1, 32'(bus_b.f), 32'(XA));
        check("idle_sel",     1, 32'({bus_b.s1, bus_b.s0}), 32'(2'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
